cpu64_muldiv_unit: RTL and testbench
====================================

CPU64_MULDIV_UNIT -- requirements
Module: cpu64_muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 64, datapath width; only 64 is supported.
REQ-002 Parameter: TAGW, default 5, width of the destination-register tag carried through.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 req_valid_i  input  1  request valid.
REQ-006 req_ready_o  output  1  unit can accept a request.
REQ-007 op_i  input  6  operation code {func7[5], func7[0], func3, opcode[3]}, as produced by the ALU decoder.
REQ-008 op_a_i  input  XLEN  rs1 operand.
REQ-009 op_b_i  input  XLEN  rs2 operand.
REQ-010 tag_i  input  TAGW  destination tag.
REQ-011 flush_i  input  1  kill any in-flight operation.
REQ-012 resp_valid_o  output  1  result valid.
REQ-013 resp_ready_i  input  1  consumer accepts the result.
REQ-014 resp_result_o  output  XLEN  result.
REQ-015 resp_tag_o  output  TAGW  tag of the result.
REQ-016 resp_illegal_o  output  1  request was not a legal RV64M operation.

Function
REQ-017 States: IDLE, MUL, DIV, DONE; req_ready_o SHALL be 1 only in IDLE.
REQ-018 Accept: req_valid_i & req_ready_o & ~flush_i at edge T; operands, op and tag are registered at T.
REQ-019 Legal ops: op_i[5]=0 and op_i[4]=1.
- op_i[0]=0: func3 000..111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- op_i[0]=1: func3 000, 100, 101, 110, 111 = MULW, DIVW, DIVUW, REMW, REMUW.
- All other codes are illegal.
REQ-020 Illegal op: go IDLE->DONE; resp_valid_o=1 from T+1; resp_result_o=0; resp_illegal_o=1.
REQ-021 Multiply ops: IDLE->MUL->DONE; resp_valid_o=1 from T+2.
REQ-022 MUL returns the low 64 bits of the product.
REQ-023 MULH, MULHSU and MULHU return the high 64 bits of a 128-bit product:
- MULH: signed x signed.
- MULHSU: signed rs1 x unsigned rs2.
- MULHU: unsigned x unsigned.
REQ-024 MULW: low 32 bits of op_a_i x op_b_i, sign-extended to 64.
REQ-025 Division ops: IDLE->DIV, then a restoring unsigned-magnitude iteration, 1 quotient bit per cycle.
- Iterations: N=64 for 64-bit ops, N=32 for W ops.
- Sign correction happens on the final cycle.
- resp_valid_o=1 from T+N+1.
REQ-026 W division operands: low 32 bits, sign-extended (DIVW, REMW) or zero-extended (DIVUW, REMUW); the 32-bit result is sign-extended to 64.
REQ-027 Signed division:
- Quotient is negative iff operand signs differ.
- Remainder takes the sign of the dividend.
- Quotient truncates toward zero.
REQ-028 Divide by zero: IDLE->DONE and resp_valid_o from T+1.
- Quotient = all ones (0xFFFF_FFFF_FFFF_FFFF; W ops sign-extend 0xFFFF_FFFF).
- Remainder = dividend (W ops: sign-extended low 32 bits).
REQ-029 Signed overflow (most-negative / -1, at 64-bit width or at 32-bit width for W ops): IDLE->DONE and resp_valid_o from T+1.
- Quotient = dividend.
- Remainder = 0.
REQ-030 DONE: outputs are held stable until resp_valid_o & resp_ready_i.
- The unit then returns to IDLE on that edge.
- A new request is accepted no earlier than the following cycle.
REQ-031 resp_tag_o SHALL equal the tag_i captured at acceptance.
REQ-032 resp_illegal_o=0 for all legal ops.
REQ-033 flush_i=1 in any state:
- Next state is IDLE and resp_valid_o=0 on the next cycle.
- No response for the killed operation is ever produced.
- A request presented in the same cycle is not accepted.
REQ-034 flush_i in DONE with resp_ready_i=1 in the same cycle: the response counts as consumed; the next state is IDLE.
REQ-035 The iteration counter SHALL NOT wrap; DIV exits exactly after N iterations.

Reset
REQ-036 While rst_ni=0, asynchronously:
- state = IDLE.
- resp_valid_o = 0, resp_result_o = 0, resp_tag_o = 0, resp_illegal_o = 0.
- Iteration counter = 0.
REQ-037 req_ready_o=1 in the first cycle after rst_ni deasserts.
REQ-038 Reset asserted mid-operation SHALL abandon the operation; no response is produced after reset is released.

Verification
REQ-039 MUL, op_a=3, op_b=0xFFFF_FFFF_FFFF_FFFB (-5), accepted at T -> resp_valid_o at T+2, result 0xFFFF_FFFF_FFFF_FFF1, tag echoed.
REQ-040 Divide-by-zero cases:
- DIVU 7/0 -> result 0xFFFF_FFFF_FFFF_FFFF at T+1.
- REMU 7/0 -> result 7 at T+1.
REQ-041 Signed overflow and W division:
- DIV 0x8000_0000_0000_0000 / -1 -> result 0x8000_0000_0000_0000 at T+1.
- REM with the same operands -> result 0 at T+1.
- DIVW, op_a low 32 bits = -7, op_b=2 -> result 0xFFFF_FFFF_FFFF_FFFD at T+33.
REQ-042 REMU 100 % 7 -> result 2 with resp_valid_o at T+65; then hold resp_ready_i=0 for 5 cycles -> result and tag stay stable and req_ready_o=0.
REQ-043 Flush and reset mid-operation:
- flush_i asserted at T+10 of a DIV -> no response; req_ready_o=1 at T+11.
- rst_ni pulsed low mid-DIV -> all outputs 0 immediately; no stale response after release.
REQ-044 Illegal code op_i={0,1,010,1} (MULHW) -> resp_illegal_o=1 with result 0 at T+1.

Source files
------------

// File: rtl/cpu64_muldiv_unit.sv
// RV64M multiply/divide unit: single-cycle multiply, restoring divide (1 bit per cycle),
// with divide-by-zero and signed-overflow results produced directly without iterating.
module cpu64_muldiv_unit #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [5:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [TAGW-1:0] tag_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_result_o,
  output logic [TAGW-1:0] resp_tag_o,
  output logic            resp_illegal_o
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q;
  logic [63:0]     a_q, b_q, rem_q, result_q;
  logic [TAGW-1:0] tag_q;
  logic            illegal_q, w_q, rem_sel_q, q_neg_q, r_neg_q;
  logic [1:0]      mul_sel_q;
  logic [5:0]      cnt_q;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Request decode and operand preparation on the accept cycle.
  logic [2:0]  f3;
  logic        w_op, legal, is_div, div_signed, div_zero, div_ovf, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, a_mag, b_mag, dividend_sx, special_res;
  always_comb begin
    f3          = op_i[3:1];
    w_op        = op_i[0];
    legal       = ~op_i[5] & op_i[4] & (~w_op | f3[2] | (f3 == 3'b000));
    is_div      = f3[2];
    div_signed  = ~f3[0];
    a_ext       = op_a_i;
    b_ext       = op_b_i;
    if (w_op) begin
      a_ext = div_signed ? sext32(op_a_i[31:0]) : {32'd0, op_a_i[31:0]};
      b_ext = div_signed ? sext32(op_b_i[31:0]) : {32'd0, op_b_i[31:0]};
    end
    a_neg       = div_signed & a_ext[63];
    b_neg       = div_signed & b_ext[63];
    a_mag       = a_neg ? -a_ext : a_ext;
    b_mag       = b_neg ? -b_ext : b_ext;
    div_zero    = (b_ext == '0);
    div_ovf     = div_signed & (b_ext == '1) &
                  (a_ext == (w_op ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    dividend_sx = w_op ? sext32(op_a_i[31:0]) : op_a_i;
    if (div_zero) special_res = f3[1] ? dividend_sx : '1;
    else          special_res = f3[1] ? '0 : dividend_sx;
  end

  // Operands are sign/zero-extended to 128 bits so a plain product yields every high-half variant.
  logic [127:0] mul_a, mul_b, prod;
  logic [63:0]  mul_res;
  always_comb begin
    mul_a   = {{64{a_q[63] & (mul_sel_q == 2'b01 || mul_sel_q == 2'b10)}}, a_q};
    mul_b   = {{64{b_q[63] & (mul_sel_q == 2'b01)}}, b_q};
    prod    = mul_a * mul_b;
    mul_res = w_q ? sext32(prod[31:0]) : ((mul_sel_q == 2'b00) ? prod[63:0] : prod[127:64]);
  end

  // One restoring step; a_q shifts dividend bits out the top and quotient bits in at the bottom.
  logic [64:0] trial;
  logic        div_ge;
  logic [63:0] rem_nx, quo_nx, q_fin, r_fin, div_sel, div_res;
  logic [5:0]  cnt_last;
  always_comb begin
    trial    = {rem_q, a_q[63]};
    div_ge   = trial >= {1'b0, b_q};
    rem_nx   = div_ge ? (trial[63:0] - b_q) : trial[63:0];
    quo_nx   = {a_q[62:0], div_ge};
    q_fin    = q_neg_q ? -quo_nx : quo_nx;
    r_fin    = r_neg_q ? -rem_nx : rem_nx;
    div_sel  = rem_sel_q ? r_fin : q_fin;
    div_res  = w_q ? sext32(div_sel[31:0]) : div_sel;
    cnt_last = w_q ? 6'd31 : 6'd63;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      tag_q     <= '0;
      illegal_q <= 1'b0;
      w_q       <= 1'b0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      mul_sel_q <= '0;
      cnt_q     <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          tag_q     <= tag_i;
          illegal_q <= 1'b0;
          cnt_q     <= '0;
          w_q       <= w_op;
          mul_sel_q <= f3[1:0];
          rem_sel_q <= f3[1];
          q_neg_q   <= a_neg ^ b_neg;
          r_neg_q   <= a_neg;
          if (!legal) begin
            illegal_q <= 1'b1;
            result_q  <= '0;
            state_q   <= S_DONE;
          end else if (!is_div) begin
            a_q     <= op_a_i;
            b_q     <= op_b_i;
            state_q <= S_MUL;
          end else if (div_zero || div_ovf) begin
            result_q <= special_res;
            state_q  <= S_DONE;
          end else begin
            // W dividends sit in the top half so 32 steps consume exactly their 32 bits.
            a_q     <= w_op ? {a_mag[31:0], 32'd0} : a_mag;
            b_q     <= b_mag;
            rem_q   <= '0;
            state_q <= S_DIV;
          end
        end
        S_MUL: begin
          result_q <= mul_res;
          state_q  <= S_DONE;
        end
        S_DIV: begin
          a_q   <= quo_nx;
          rem_q <= rem_nx;
          if (cnt_q == cnt_last) begin
            result_q <= div_res;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DONE: if (resp_ready_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o    = (state_q == S_IDLE);
  assign resp_valid_o   = (state_q == S_DONE);
  assign resp_result_o  = result_q;
  assign resp_tag_o     = tag_q;
  assign resp_illegal_o = illegal_q;
endmodule

// File: tb/tb_cpu64_muldiv_unit.sv
// Self-checking bench for cpu64_muldiv_unit: arithmetic reference model plus directed vectors.
module tb_cpu64_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0, resp_ready = 1'b0;
  logic [5:0]  op = '0;
  logic [63:0] a = '0, b = '0;
  logic [4:0]  tag = '0;
  logic        req_ready, resp_valid, resp_illegal;
  logic [63:0] resp_result;
  logic [4:0]  resp_tag;
  int          n_checks = 0, n_fail = 0;

  cpu64_muldiv_unit #(.XLEN(64), .TAGW(5)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .op_a_i(a), .op_b_i(b), .tag_i(tag), .flush_i(flush),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_result_o(resp_result),
    .resp_tag_o(resp_tag), .resp_illegal_o(resp_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ill;
    logic [63:0] res;
    logic [7:0]  lat;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: RV64M semantics straight from the ISA rules, latency in cycles after acceptance.
  function automatic exp_t ref_model(input logic [5:0] o, input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    logic [2:0] f3;
    logic w, sgn;
    logic signed [127:0] p;
    logic [63:0] q, r, lo;
    logic [31:0] x32, y32, q32, r32;
    e.ill = 1'b0; e.res = '0; e.lat = 8'd1;
    f3 = o[3:1]; w = o[0];
    if (o[5] || !o[4] || (w && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011))) begin
      e.ill = 1'b1;
      return e;
    end
    if (!f3[2]) begin
      e.lat = 8'd2;
      lo = x * y;
      case (f3[1:0])
        2'b00: p = '0;
        2'b01: p = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y});
        2'b10: p = $signed({{64{x[63]}}, x}) * $signed({64'd0, y});
        default: p = $signed({64'd0, x} * {64'd0, y});
      endcase
      if (w) e.res = {{32{lo[31]}}, lo[31:0]};
      else   e.res = (f3[1:0] == 2'b00) ? lo : p[127:64];
      return e;
    end
    sgn = !f3[0];
    if (w) begin
      x32 = x[31:0]; y32 = y[31:0];
      if (y32 == 0) begin q32 = '1; r32 = x32; end
      else if (sgn && x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) begin q32 = x32; r32 = '0; end
      else begin
        e.lat = 8'd33;
        if (sgn) begin q32 = $signed(x32) / $signed(y32); r32 = $signed(x32) % $signed(y32); end
        else     begin q32 = x32 / y32; r32 = x32 % y32; end
      end
      e.res = f3[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end else begin
      if (y == 0) begin q = '1; r = x; end
      else if (sgn && x == 64'h8000_0000_0000_0000 && y == '1) begin q = x; r = '0; end
      else begin
        e.lat = 8'd65;
        if (sgn) begin q = $signed(x) / $signed(y); r = $signed(x) % $signed(y); end
        else     begin q = x / y; r = x % y; end
      end
      e.res = f3[1] ? r : q;
    end
    return e;
  endfunction

  // Transaction-level model: one outstanding op, counts down its latency, then holds until consumed.
  bit         m_busy = 1'b0;
  int         m_left = 0;
  exp_t       m_exp;
  logic [4:0] m_tag;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_left = 0;
    end else if (flush) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_left == 0) begin
        if (resp_ready) m_busy = 1'b0;
      end else m_left--;
    end else if (req_valid) begin
      m_exp  = ref_model(op, a, b);
      m_tag  = tag;
      m_busy = 1'b1;
      m_left = int'(m_exp.lat) - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 64'(resp_valid), 64'd0);
      chk("rst_result", resp_result, 64'd0);
      chk("rst_tag", 64'(resp_tag), 64'd0);
      chk("rst_illegal", 64'(resp_illegal), 64'd0);
    end else begin
      chk("ready", 64'(req_ready), 64'(!m_busy));
      chk("valid", 64'(resp_valid), 64'(m_busy && m_left == 0));
      if (m_busy && m_left == 0) begin
        chk("result", resp_result, m_exp.res);
        chk("tag", 64'(resp_tag), 64'(m_tag));
        chk("illegal", 64'(resp_illegal), 64'(m_exp.ill));
      end
    end
  end

  task automatic issue(input logic [5:0] o, input logic [63:0] x, input logic [63:0] y,
                       input logic [4:0] t);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) chk("ready_timeout", 64'd0, 64'd1);
    op = o; a = x; b = y; tag = t; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [5:0] o, input logic [63:0] x,
                        input logic [63:0] y, input logic [4:0] t, input logic [63:0] exp_res,
                        input bit exp_ill, input int exp_lat, input int hold);
    exp_t e;
    int c;
    e = ref_model(o, x, y);
    chk({name, "_model_res"}, e.res, exp_res);
    chk({name, "_model_lat"}, 64'(e.lat), 64'(exp_lat));
    issue(o, x, y, t);
    c = 1;
    while (!resp_valid && c < 200) begin @(negedge clk); c++; end
    chk({name, "_lat"}, 64'(c), 64'(exp_lat));
    chk({name, "_res"}, resp_result, exp_res);
    chk({name, "_ill"}, 64'(resp_illegal), 64'(exp_ill));
    chk({name, "_tag"}, 64'(resp_tag), 64'(t));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_res"}, resp_result, exp_res);
      chk({name, "_hold_tag"}, 64'(resp_tag), 64'(t));
      chk({name, "_hold_busy"}, 64'(req_ready), 64'd0);
    end
    $display("txn %s op=%b a=%h b=%h tag=%0d -> result=%h illegal=%0b latency=%0d",
             name, o, x, y, t, resp_result, resp_illegal, c);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int seen;
    #1;
    chk("rst_init_valid", 64'(resp_valid), 64'd0);
    chk("rst_init_ready", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    run_op("MUL",      6'b010000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'h11, 64'hFFFF_FFFF_FFFF_FFF1, 0, 2, 0);
    run_op("DIVU_z",   6'b011010, 64'd7, 64'd0, 5'h02, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
    run_op("REMU_z",   6'b011110, 64'd7, 64'd0, 5'h03, 64'd7, 0, 1, 0);
    run_op("DIV_ovf",  6'b011000, 64'h8000_0000_0000_0000, '1, 5'h04, 64'h8000_0000_0000_0000, 0, 1, 0);
    run_op("REM_ovf",  6'b011100, 64'h8000_0000_0000_0000, '1, 5'h05, 64'd0, 0, 1, 0);
    run_op("DIVW",     6'b011001, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'h06, 64'hFFFF_FFFF_FFFF_FFFD, 0, 33, 0);
    run_op("REMU",     6'b011110, 64'd100, 64'd7, 5'h07, 64'd2, 0, 65, 5);
    run_op("MULHW",    6'b010101, 64'd5, 64'd6, 5'h08, 64'd0, 1, 1, 0);
    run_op("MULHU",    6'b010110, '1, '1, 5'h09, 64'hFFFF_FFFF_FFFF_FFFE, 0, 2, 0);
    run_op("MULH",     6'b010010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'h0A, 64'h4000_0000_0000_0000, 0, 2, 0);
    run_op("MULHSU",   6'b010100, '1, 64'd2, 5'h0B, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2, 0);
    run_op("MULW",     6'b010001, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'h0C, 64'hFFFF_FFFF_FFFF_FFFE, 0, 2, 0);
    run_op("DIV",      6'b011000, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'h0D, 64'hFFFF_FFFF_FFFF_FFFA, 0, 65, 0);
    run_op("REM",      6'b011100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'h0E, 64'hFFFF_FFFF_FFFF_FFFE, 0, 65, 0);
    run_op("REMW",     6'b011101, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 33, 0);
    run_op("DIVUW",    6'b011011, 64'hAAAA_AAAA_FFFF_FFFF, 64'd16, 5'h10, 64'h0000_0000_0FFF_FFFF, 0, 33, 0);
    run_op("DIVW_ovf", 6'b011001, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'h12, 64'hFFFF_FFFF_8000_0000, 0, 1, 0);
    run_op("REMUW_z",  6'b011111, 64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000, 5'h13, 64'hFFFF_FFFF_8000_0005, 0, 1, 0);
    run_op("DIVU_max", 6'b011010, '1, 64'd1, 5'h14, 64'hFFFF_FFFF_FFFF_FFFF, 0, 65, 0);
    run_op("ILL_f7",   6'b110000, 64'd9, 64'd9, 5'h15, 64'd0, 1, 1, 0);
    run_op("ILL_w011", 6'b010111, 64'd9, 64'd9, 5'h16, 64'd0, 1, 1, 0);
    run_op("ILL_add",  6'b000000, 64'd9, 64'd9, 5'h17, 64'd0, 1, 1, 0);

    // Flush ten cycles into a long divide.
    issue(6'b011000, 64'd1000, 64'd7, 5'h18);
    c = 1;
    while (c < 10) begin @(negedge clk); c++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 64'(req_ready), 64'd1);
    chk("flush_valid", 64'(resp_valid), 64'd0);
    seen = 0;
    repeat (70) begin @(negedge clk); if (resp_valid) seen++; end
    chk("flush_no_resp", 64'(seen), 64'd0);
    $display("txn flush_div tag=%0d -> responses=%0d", 5'h18, seen);

    // Request presented alongside flush is dropped.
    @(negedge clk);
    op = 6'b010000; a = 64'd2; b = 64'd3; tag = 5'h19; req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_req_ready", 64'(req_ready), 64'd1);
    seen = 0;
    repeat (4) begin @(negedge clk); if (resp_valid) seen++; end
    chk("flush_req_no_resp", 64'(seen), 64'd0);
    $display("txn flush_with_req tag=%0d -> responses=%0d", 5'h19, seen);

    // Flush together with consumption in DONE.
    issue(6'b010000, 64'd6, 64'd7, 5'h1B);
    c = 1;
    while (!resp_valid && c < 20) begin @(negedge clk); c++; end
    chk("flushdone_res", resp_result, 64'd42);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0;
    chk("flushdone_valid", 64'(resp_valid), 64'd0);
    chk("flushdone_ready", 64'(req_ready), 64'd1);
    $display("txn flush_in_done tag=%0d -> valid=%0b ready=%0b", 5'h1B, resp_valid, req_ready);

    // Asynchronous reset in the middle of a divide.
    issue(6'b011000, 64'd5000, 64'd3, 5'h1A);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(resp_valid), 64'd0);
    chk("arst_result", resp_result, 64'd0);
    chk("arst_tag", 64'(resp_tag), 64'd0);
    chk("arst_illegal", 64'(resp_illegal), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (80) begin @(negedge clk); if (resp_valid) seen++; end
    chk("arst_no_resp", 64'(seen), 64'd0);
    $display("txn reset_mid_div tag=%0d -> responses=%0d", 5'h1A, seen);

    run_op("MUL_post", 6'b010000, 64'd11, 64'd13, 5'h1C, 64'd143, 0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
